// File: rtl/rdback_serializer_pkg.sv
// Shared definitions for the read-back serializer: FSM state encodings and a
// helper that sizes the word index.
package rdback_serializer_pkg;

  typedef enum logic {
    RDS_IDLE = 1'b0,
    RDS_SEND = 1'b1
  } rds_state_e;

  // Word index width; a one-word beat still needs a 1-bit index.
  function automatic int idx_width(input int n_words);
    return (n_words > 1) ? $clog2(n_words) : 1;
  endfunction

endpackage

// File: rtl/rdback_serializer.sv
// Pops one read-back beat from the softMC FIFO and streams it to the host as
// OUT_WIDTH-bit words, least-significant first, over valid/ready.
module rdback_serializer
  import rdback_serializer_pkg::*;
#(
  parameter int TCQ       = 100,
  parameter int DQ_WIDTH  = 64,
  parameter int OUT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdback_fifo_empty,
  output logic                    rdback_fifo_rden,
  input  logic [4*DQ_WIDTH-1:0]   rdback_data,
  input  logic                    flush,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic [15:0]             beat_cnt
);

  localparam int BEAT_W  = 4 * DQ_WIDTH;
  localparam int N_WORDS = BEAT_W / OUT_WIDTH;
  localparam int IDX_W   = idx_width(N_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  if ((BEAT_W % OUT_WIDTH) != 0 || N_WORDS < 1 || TCQ < 0) begin : g_bad_params
    $error("rdback_serializer: beat width must be a positive multiple of OUT_WIDTH");
  end

  rds_state_e        state;
  logic [IDX_W-1:0]  word_idx;
  logic [BEAT_W-1:0] beat_reg;
  logic              handshake;
  logic              last_hs;
  logic              pop;

  assign out_valid = (state == RDS_SEND);
  assign busy      = out_valid;
  assign out_last  = out_valid && (word_idx == LAST_IDX);
  assign out_data  = beat_reg[int'(word_idx)*OUT_WIDTH +: OUT_WIDTH];

  assign handshake = out_valid && out_ready;
  assign last_hs   = handshake && (word_idx == LAST_IDX);

  // Reloading on the last-word handshake gives bubble-free back-to-back beats;
  // reset and flush both suppress the pop so the FIFO head is never lost.
  assign pop = !rst && !flush && !rdback_fifo_empty && ((state == RDS_IDLE) || last_hs);
  assign rdback_fifo_rden = pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RDS_IDLE;
      word_idx <= '0;
      beat_reg <= '0;
      beat_cnt <= '0;
    end else begin
      if (last_hs) begin
        beat_cnt <= beat_cnt + 16'd1;
      end
      if (flush) begin
        state    <= RDS_IDLE;
        word_idx <= '0;
      end else if (pop) begin
        state    <= RDS_SEND;
        word_idx <= '0;
        beat_reg <= rdback_data;
      end else if (last_hs) begin
        state    <= RDS_IDLE;
        word_idx <= '0;
      end else if (handshake) begin
        word_idx <= word_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rdback_serializer.sv
// Randomized bench for rdback_serializer: a queue-based FIFO and word-stream
// reference model, plus a one-word-per-beat instance.
module tb_rdback_serializer;

  localparam int DQ_WIDTH  = 64;
  localparam int OUT_WIDTH = 32;
  localparam int N_WORDS   = 8;
  localparam int BEAT_W    = 4 * DQ_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rdback_fifo_empty;
  logic                 rdback_fifo_rden;
  logic [BEAT_W-1:0]    rdback_data;
  logic                 flush;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 busy;
  logic [15:0]          beat_cnt;

  logic                 empty2;
  logic                 rden2;
  logic [31:0]          data2;
  logic                 flush2;
  logic [31:0]          out_data2;
  logic                 valid2;
  logic                 ready2;
  logic                 last2;
  logic                 busy2;
  logic [15:0]          cnt2;

  always #5 clk = ~clk;

  rdback_serializer #(.TCQ(100), .DQ_WIDTH(DQ_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_dut (
    .clk(clk), .rst(rst),
    .rdback_fifo_empty(rdback_fifo_empty), .rdback_fifo_rden(rdback_fifo_rden),
    .rdback_data(rdback_data), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .beat_cnt(beat_cnt)
  );

  rdback_serializer #(.TCQ(100), .DQ_WIDTH(8), .OUT_WIDTH(32)) u_dut_n1 (
    .clk(clk), .rst(rst),
    .rdback_fifo_empty(empty2), .rdback_fifo_rden(rden2),
    .rdback_data(data2), .flush(flush2),
    .out_data(out_data2), .out_valid(valid2), .out_ready(ready2),
    .out_last(last2), .busy(busy2), .beat_cnt(cnt2)
  );

  logic [BEAT_W-1:0]    fifo_q[$];
  logic [OUT_WIDTH-1:0] pend[$];
  logic [15:0]          exp_cnt;
  logic [31:0]          fifo2[$];
  int                   n_cmp = 0;
  int                   n_err = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic syncFifo();
    rdback_fifo_empty = (fifo_q.size() == 0);
    rdback_data       = rdback_fifo_empty ? '0 : fifo_q[0];
    empty2            = (fifo2.size() == 0);
    data2             = empty2 ? '0 : fifo2[0];
  endtask

  task automatic pushBeat(input logic [BEAT_W-1:0] b);
    fifo_q.push_back(b);
    syncFifo();
  endtask

  function automatic logic [BEAT_W-1:0] randBeat();
    logic [BEAT_W-1:0] b;
    for (int k = 0; k < N_WORDS; k++) b[k*OUT_WIDTH +: OUT_WIDTH] = $urandom;
    return b;
  endfunction

  // A pop is due when nothing is held, or when the last word is being accepted.
  function automatic logic modelPop(input logic rdy, input logic fl);
    return !fl && (fifo_q.size() != 0) &&
           ((pend.size() == 0) || (rdy && pend.size() == 1));
  endfunction

  task automatic checkOutput(input logic rdy, input logic fl);
    cmp("rden", 32'(rdback_fifo_rden), 32'(modelPop(rdy, fl)));
    cmp("out_valid", 32'(out_valid), 32'(pend.size() != 0));
    cmp("busy", 32'(busy), 32'(pend.size() != 0));
    cmp("beat_cnt", 32'(beat_cnt), 32'(exp_cnt));
    if (pend.size() != 0) begin
      cmp("out_data", out_data, pend[0]);
      cmp("out_last", 32'(out_last), 32'(pend.size() == 1));
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic fl);
    logic              p;
    logic [BEAT_W-1:0] head;
    out_ready = rdy;
    flush     = fl;
    #1;
    checkOutput(rdy, fl);
    p    = modelPop(rdy, fl);
    head = '0;
    if (p) head = fifo_q[0];
    if (rdy && pend.size() != 0) begin
      if (pend.size() == 1) exp_cnt = exp_cnt + 16'd1;
      void'(pend.pop_front());
    end
    if (fl) pend.delete();
    else if (p) for (int k = 0; k < N_WORDS; k++) pend.push_back(head[k*OUT_WIDTH +: OUT_WIDTH]);
    @(posedge clk);
    #1;
    if (p) begin
      void'(fifo_q.pop_front());
      syncFifo();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [BEAT_W-1:0] cnt_beat;
    logic              holding2;
    logic              p2;
    logic [31:0]       cur2;
    logic [15:0]       exp_cnt2;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; flush2 = 1'b0; ready2 = 1'b0;
    exp_cnt = '0;
    syncFifo();
    for (int k = 0; k < N_WORDS; k++) cnt_beat[k*OUT_WIDTH +: OUT_WIDTH] = 32'(k);
    pushBeat(cnt_beat);
    #3;
    cmp("rst_rden", 32'(rdback_fifo_rden), 32'd0);
    cmp("rst_valid", 32'(out_valid), 32'd0);
    cmp("rst_last", 32'(out_last), 32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_cnt", 32'(beat_cnt), 32'd0);
    cmp("rst_data", out_data, 32'd0);
    cmp("rst_valid2", 32'(valid2), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] single counting beat");
    repeat (10) applyStimulus(1'b1, 1'b0);
    cmp("single_cnt", 32'(beat_cnt), 32'd1);

    $display("[TB] three queued beats, back to back");
    repeat (3) pushBeat(randBeat());
    repeat (26) applyStimulus(1'b1, 1'b0);
    cmp("three_cnt", 32'(beat_cnt), 32'd4);

    $display("[TB] stalled and random ready");
    repeat (2) pushBeat(randBeat());
    for (int i = 0; i < 30; i++) applyStimulus((i % 3) == 0, 1'b0);
    pushBeat(randBeat());
    for (int i = 0; i < 20; i++) applyStimulus(1'($urandom_range(0, 1)), 1'b0);
    repeat (20) applyStimulus(1'b1, 1'b0);

    $display("[TB] flush mid-beat");
    repeat (2) pushBeat(randBeat());
    repeat (5) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    repeat (10) applyStimulus(1'b1, 1'b0);

    $display("[TB] async reset mid-beat");
    pushBeat(randBeat());
    repeat (6) applyStimulus(1'b1, 1'b0);
    pushBeat(randBeat());
    out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    cmp("arst_valid", 32'(out_valid), 32'd0);
    cmp("arst_busy", 32'(busy), 32'd0);
    cmp("arst_cnt", 32'(beat_cnt), 32'd0);
    cmp("arst_rden", 32'(rdback_fifo_rden), 32'd0);
    cmp("arst_last", 32'(out_last), 32'd0);
    pend.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) applyStimulus(1'b1, 1'b0);

    $display("[TB] one word per beat instance");
    holding2 = 1'b0; cur2 = '0; exp_cnt2 = '0;
    repeat (3) fifo2.push_back($urandom);
    syncFifo();
    for (int c = 0; c < 6; c++) begin
      ready2 = 1'b1;
      #1;
      p2 = (fifo2.size() != 0);
      cmp("n1_rden", 32'(rden2), 32'(p2));
      cmp("n1_valid", 32'(valid2), 32'(holding2));
      cmp("n1_cnt", 32'(cnt2), 32'(exp_cnt2));
      if (holding2) begin
        cmp("n1_data", out_data2, cur2);
        cmp("n1_last", 32'(last2), 32'd1);
      end
      if (holding2) begin
        exp_cnt2 = exp_cnt2 + 16'd1;
        holding2 = 1'b0;
      end
      if (p2) begin
        cur2     = fifo2[0];
        holding2 = 1'b1;
      end
      @(posedge clk);
      #1;
      if (p2) begin
        void'(fifo2.pop_front());
        syncFifo();
      end
      @(negedge clk);
    end
    cmp("n1_final_cnt", 32'(cnt2), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
